cdb_broadcast: RTL and testbench

//  Write-back end of the Tomasulo issue path. Collects completed results (tag+value) from functional units.

---
 rtl/tomasulo_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/cdb_broadcast.sv | 129 ++++++++++++
 tb/tb_cdb_broadcast.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared widths, tag encoding and instruction field positions for the Tomasulo issue path
package tomasulo_pkg;
   localparam int TAG_W    = 3;
   localparam int DATA_W   = 8;
   localparam int REG_AW   = 3;
   localparam int NUM_REGS = 1 << REG_AW;
   localparam int NUM_TAGS = 1 << TAG_W;

   localparam logic [TAG_W-1:0] TAG_NONE = '0;

   // Instruction field positions used by the issue stage when driving the read/claim addresses
   localparam int DEST_HI = 12;
   localparam int DEST_LO = 10;
   localparam int SRCJ_HI = 9;
   localparam int SRCJ_LO = 7;
   localparam int SRCK_HI = 6;
   localparam int SRCK_LO = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first request at or after ptr wins, one-hot grant plus index
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   always_comb begin
      int cand;
      cand      = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int off = 0; off < N; off++) begin
         cand = int'(ptr) + off;
         if (cand >= N) cand = cand - N;
         if (!grant_any && req[cand]) begin
            grant_any   = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/cdb_broadcast.sv
// rtl/cdb_broadcast.sv - CDB write-back: FU result holders, round-robin CDB arbitration, register file and status table
// Optional same-cycle CDB forwarding on the read ports when CDB_BYPASS_EN is defined.
module cdb_broadcast
   import tomasulo_pkg::*;
#(
   parameter int NUM_FU = 2
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [NUM_FU-1:0]        fu_valid,
   input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
   input  logic [NUM_FU*DATA_W-1:0] fu_value,
   output logic [NUM_FU-1:0]        fu_ready,
   input  logic                     issue_we,
   input  logic [REG_AW-1:0]        issue_dest,
   input  logic [TAG_W-1:0]         issue_tag,
   input  logic [REG_AW-1:0]        rd_addr_j,
   input  logic [REG_AW-1:0]        rd_addr_k,
   output logic [TAG_W-1:0]         qj,
   output logic [TAG_W-1:0]         qk,
   output logic [DATA_W-1:0]        vj,
   output logic [DATA_W-1:0]        vk,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [DATA_W-1:0]        cdb_value,
   output logic [NUM_TAGS-1:0]      rs_release
);

   localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0] hold_full;
   logic [TAG_W-1:0]  hold_tag   [NUM_FU];
   logic [DATA_W-1:0] hold_value [NUM_FU];
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  grant_idx;
   logic [NUM_FU-1:0] grant;
   logic              grant_any;
   logic [TAG_W-1:0]  status [NUM_REGS];
   logic [DATA_W-1:0] regs   [NUM_REGS];

   assign fu_ready = ~hold_full;

   rr_arbiter #(.N(NUM_FU), .IW(IDX_W)) u_arb (
      .req       (hold_full),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // A granted holder reads as full this cycle, so it cannot also accept a new result.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hold_full <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            hold_tag[i]   <= TAG_NONE;
            hold_value[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
               hold_full[i] <= 1'b0;
            end else if (fu_valid[i] && !hold_full[i] &&
                         fu_tag[i*TAG_W +: TAG_W] != TAG_NONE) begin
               hold_full[i]  <= 1'b1;
               hold_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
               hold_value[i] <= fu_value[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= TAG_NONE;
         cdb_value <= '0;
         rr_ptr    <= '0;
      end else begin
         cdb_valid <= grant_any;
         if (grant_any) begin
            cdb_tag   <= hold_tag[grant_idx];
            cdb_value <= hold_value[grant_idx];
            rr_ptr    <= (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);
         end
      end
   end

   // Issue is written after commit so a same-edge claim leaves the newer producer in the status table.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            status[r] <= TAG_NONE;
            regs[r]   <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (cdb_valid && status[r] == cdb_tag) begin
               regs[r]   <= cdb_value;
               status[r] <= TAG_NONE;
            end
         end
         if (issue_we) status[issue_dest] <= issue_tag;
      end
   end

   always_comb begin
      rs_release = '0;
      if (cdb_valid) rs_release[cdb_tag] = 1'b1;
   end

   always_comb begin
      qj = status[rd_addr_j];
      vj = regs[rd_addr_j];
      qk = status[rd_addr_k];
      vk = regs[rd_addr_k];
`ifdef CDB_BYPASS_EN
      if (cdb_valid && status[rd_addr_j] == cdb_tag) begin
         qj = TAG_NONE;
         vj = cdb_value;
      end
      if (cdb_valid && status[rd_addr_k] == cdb_tag) begin
         qk = TAG_NONE;
         vk = cdb_value;
      end
`endif
   end

endmodule

// File: tb/tb_cdb_broadcast.sv
// tb/tb_cdb_broadcast.sv - scoreboard bench for cdb_broadcast
module tb_cdb_broadcast;
   import tomasulo_pkg::*;

   logic                 Clock = 1'b0;
   logic                 Reset;
   logic [1:0]           fu_valid;
   logic [2*TAG_W-1:0]   fu_tag;
   logic [2*DATA_W-1:0]  fu_value;
   logic [1:0]           fu_ready;
   logic                 issue_we;
   logic [REG_AW-1:0]    issue_dest;
   logic [TAG_W-1:0]     issue_tag;
   logic [REG_AW-1:0]    rd_addr_j;
   logic [REG_AW-1:0]    rd_addr_k;
   logic [TAG_W-1:0]     qj, qk;
   logic [DATA_W-1:0]    vj, vk;
   logic                 cdb_valid;
   logic [TAG_W-1:0]     cdb_tag;
   logic [DATA_W-1:0]    cdb_value;
   logic [NUM_TAGS-1:0]  rs_release;

   int checks   = 0;
   int failures = 0;
   logic [TAG_W+DATA_W-1:0] sb[$];

   cdb_broadcast #(.NUM_FU(2)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .fu_valid   (fu_valid),
      .fu_tag     (fu_tag),
      .fu_value   (fu_value),
      .fu_ready   (fu_ready),
      .issue_we   (issue_we),
      .issue_dest (issue_dest),
      .issue_tag  (issue_tag),
      .rd_addr_j  (rd_addr_j),
      .rd_addr_k  (rd_addr_k),
      .qj         (qj),
      .qk         (qk),
      .vj         (vj),
      .vk         (vk),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_value  (cdb_value),
      .rs_release (rs_release)
   );

   always #5 Clock = ~Clock;

   // Every broadcast is matched against the oldest expected result.
   always @(negedge Clock) begin
      if (cdb_valid) begin
         logic [TAG_W+DATA_W-1:0] exp_e;
         logic [NUM_TAGS-1:0]     exp_rel;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL cdb_unexpected: got tag=%0d value=%h, required no broadcast", cdb_tag, cdb_value);
         end else begin
            exp_e   = sb.pop_front();
            exp_rel = '0;
            exp_rel[exp_e[TAG_W+DATA_W-1 -: TAG_W]] = 1'b1;
            if ({cdb_tag, cdb_value} !== exp_e || rs_release !== exp_rel) begin
               failures++;
               $display("FAIL cdb_result: got tag=%0d value=%h rel=%b, required tag=%0d value=%h rel=%b",
                        cdb_tag, cdb_value, rs_release, exp_e[TAG_W+DATA_W-1 -: TAG_W],
                        exp_e[DATA_W-1:0], exp_rel);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_fu(input int i, input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
      fu_valid[i]                = v;
      fu_tag[i*TAG_W +: TAG_W]   = t;
      fu_value[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic issue(input logic [REG_AW-1:0] r, input logic [TAG_W-1:0] t);
      issue_we = 1'b1; issue_dest = r; issue_tag = t;
      tick();
      issue_we = 1'b0;
   endtask

   task automatic test_reset_state();
      rd_addr_j = 3'd2; rd_addr_k = 3'd5;
      checks++;
      if (cdb_valid !== 1'b0 || fu_ready !== 2'b11 || qj !== 3'd0 || qk !== 3'd0 ||
          vj !== 8'h00 || rs_release !== 8'h00) begin
         failures++;
         $display("FAIL reset_state: got v=%b rdy=%b qj=%0d qk=%0d vj=%h rel=%b, required 0 11 0 0 00 0",
                  cdb_valid, fu_ready, qj, qk, vj, rs_release);
      end
   endtask

   task automatic test_single();
      issue(3'd2, 3'd1);
      rd_addr_j = 3'd2;
      checks++;
      if (qj !== 3'd1) begin failures++; $display("FAIL single_issue_q: got %0d required 1", qj); end
      sb.push_back({3'd1, 8'h5A});
      set_fu(0, 1'b1, 3'd1, 8'h5A);
      tick();
      set_fu(0, 1'b0, 3'd0, 8'h00);
      checks++;
      if (fu_ready !== 2'b10 || cdb_valid !== 1'b0) begin
         failures++; $display("FAIL single_held: got rdy=%b v=%b required 10 0", fu_ready, cdb_valid);
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || fu_ready !== 2'b11) begin
         failures++; $display("FAIL single_latency: got v=%b rdy=%b required 1 11", cdb_valid, fu_ready);
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b0 || qj !== 3'd0 || vj !== 8'h5A) begin
         failures++; $display("FAIL single_commit: got v=%b qj=%0d vj=%h required 0 0 5a", cdb_valid, qj, vj);
      end
   endtask

   task automatic tie(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                      input logic [1:0] rdy_mid, input string nm);
      set_fu(0, 1'b1, 3'd2, d0);
      set_fu(1, 1'b1, 3'd4, d1);
      tick();
      set_fu(0, 1'b0, 3'd0, 8'h00);
      set_fu(1, 1'b0, 3'd0, 8'h00);
      tick();
      checks++;
      if (fu_ready !== rdy_mid) begin
         failures++; $display("FAIL %s_ready: got %b required %b", nm, fu_ready, rdy_mid);
      end
      tick();
      checks++;
      if (fu_ready !== 2'b11 || cdb_valid !== 1'b1) begin
         failures++; $display("FAIL %s_second: got rdy=%b v=%b required 11 1", nm, fu_ready, cdb_valid);
      end
      tick();
   endtask

   task automatic test_contention();
      // A stale FU1 result moves the pointer back to FU0 before the first tie.
      sb.push_back({3'd3, 8'h33});
      set_fu(1, 1'b1, 3'd3, 8'h33);
      tick();
      set_fu(1, 1'b0, 3'd0, 8'h00);
      tick();
      tick();
      sb.push_back({3'd2, 8'h22});
      sb.push_back({3'd4, 8'h44});
      tie(8'h22, 8'h44, 2'b01, "tie_fu0_first");
      sb.push_back({3'd2, 8'h24});
      set_fu(0, 1'b1, 3'd2, 8'h24);
      tick();
      set_fu(0, 1'b0, 3'd0, 8'h00);
      tick();
      tick();
      sb.push_back({3'd4, 8'h46});
      sb.push_back({3'd2, 8'h25});
      tie(8'h25, 8'h46, 2'b10, "tie_fu1_first");
   endtask

   task automatic test_race();
      issue(3'd3, 3'd3);
      sb.push_back({3'd3, 8'h77});
      set_fu(0, 1'b1, 3'd3, 8'h77);
      tick();
      set_fu(0, 1'b0, 3'd0, 8'h00);
      tick();
      issue(3'd3, 3'd5);
      rd_addr_j = 3'd3;
      checks++;
      if (qj !== 3'd5 || vj !== 8'h77) begin
         failures++; $display("FAIL race: got qj=%0d vj=%h required 5 77", qj, vj);
      end
   endtask

   task automatic test_multi_dest();
      issue(3'd1, 3'd7);
      issue(3'd6, 3'd7);
      sb.push_back({3'd7, 8'h11});
      set_fu(1, 1'b1, 3'd7, 8'h11);
      tick();
      set_fu(1, 1'b0, 3'd0, 8'h00);
      tick();
      tick();
      rd_addr_j = 3'd1; rd_addr_k = 3'd6;
      checks++;
      if (qj !== 3'd0 || qk !== 3'd0 || vj !== 8'h11 || vk !== 8'h11) begin
         failures++; $display("FAIL multi_dest: got qj=%0d qk=%0d vj=%h vk=%h required 0 0 11 11", qj, qk, vj, vk);
      end
      set_fu(0, 1'b1, 3'd0, 8'h99);
      tick();
      set_fu(0, 1'b0, 3'd0, 8'h00);
      checks++;
      if (fu_ready !== 2'b11 || cdb_valid !== 1'b0) begin
         failures++; $display("FAIL tag0_drop: got rdy=%b v=%b required 11 0", fu_ready, cdb_valid);
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b0) begin failures++; $display("FAIL tag0_no_cdb: got %b required 0", cdb_valid); end
   endtask

   task automatic test_bypass();
      logic [TAG_W-1:0]  exp_q;
      logic [DATA_W-1:0] exp_v;
      issue(3'd4, 3'd6);
      sb.push_back({3'd6, 8'h3C});
      set_fu(0, 1'b1, 3'd6, 8'h3C);
      tick();
      set_fu(0, 1'b0, 3'd0, 8'h00);
      tick();
      rd_addr_j = 3'd4;
      #1;
`ifdef CDB_BYPASS_EN
      exp_q = 3'd0; exp_v = 8'h3C;
`else
      exp_q = 3'd6; exp_v = 8'h00;
`endif
      checks++;
      if (cdb_valid !== 1'b1 || qj !== exp_q || vj !== exp_v) begin
         failures++; $display("FAIL bypass_same_cycle: got v=%b qj=%0d vj=%h required 1 %0d %h", cdb_valid, qj, vj, exp_q, exp_v);
      end
      tick();
      checks++;
      if (qj !== 3'd0 || vj !== 8'h3C) begin
         failures++; $display("FAIL bypass_after: got qj=%0d vj=%h required 0 3c", qj, vj);
      end
   endtask

   task automatic test_reset_mid();
      issue(3'd5, 3'd1);
      set_fu(0, 1'b1, 3'd1, 8'h66);
      set_fu(1, 1'b1, 3'd2, 8'h67);
      tick();
      set_fu(0, 1'b0, 3'd0, 8'h00);
      set_fu(1, 1'b0, 3'd0, 8'h00);
      tick();
      checks++;
      if (cdb_valid !== 1'b1) begin failures++; $display("FAIL reset_pre_bcast: got %b required 1", cdb_valid); end
      Reset = 1'b1;
      rd_addr_j = 3'd5; rd_addr_k = 3'd1;
      #1;
      checks++;
      if (cdb_valid !== 1'b0 || qj !== 3'd0 || qk !== 3'd0 || fu_ready !== 2'b11 || rs_release !== 8'h00) begin
         failures++; $display("FAIL reset_async: got v=%b qj=%0d qk=%0d rdy=%b rel=%b required 0 0 0 11 0",
                              cdb_valid, qj, qk, fu_ready, rs_release);
      end
      tick();
      Reset = 1'b0;
      tick();
      tick();
      checks++;
      if (cdb_valid !== 1'b0 || vj !== 8'h00 || qj !== 3'd0) begin
         failures++; $display("FAIL reset_no_commit: got v=%b vj=%h qj=%0d required 0 00 0", cdb_valid, vj, qj);
      end
   endtask

   initial begin
      Reset = 1'b1;
      fu_valid = '0; fu_tag = '0; fu_value = '0;
      issue_we = 1'b0; issue_dest = '0; issue_tag = '0;
      rd_addr_j = '0; rd_addr_k = '0;
      tick();
      tick();
      test_reset_state();
      Reset = 1'b0;
      tick();
      test_single();
      test_contention();
      test_race();
      test_multi_dest();
      test_bypass();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
